result_packer: RTL and testbench



---
 rtl/result_packer.sv | 131 +++++++++++++
 tb/tb_result_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// Packs result words into wide lines. Word k of a line lands in slot k; a job's last word
// pads the unused slots and marks the line. One assembly register feeds one output register.
//
// state  | meaning
// S_FILL | assembly register accepting result words
// S_HOLD | line complete, output register occupied and not draining
module result_packer #(
  parameter int G_DATA_BUS_WIDTH = 512,
  parameter int G_RESULT_WIDTH = 32,
  parameter logic [G_RESULT_WIDTH-1:0] G_PAD_VALUE = '1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [G_RESULT_WIDTH-1:0]   res_data_i,
  input  logic                        res_valid_i,
  input  logic                        res_last_i,
  output logic                        res_ready_o,
  output logic [G_DATA_BUS_WIDTH-1:0] wr_data_o,
  output logic                        wr_valid_o,
  output logic                        wr_last_o,
  input  logic                        wr_ready_i,
  output logic [31:0]                 lines_o,
  output logic                        done_o
);
  localparam int N = G_DATA_BUS_WIDTH / G_RESULT_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               idx_q;
  logic [G_DATA_BUS_WIDTH-1:0] asm_q, line_cmp, out_data_q;
  logic                        hold_last_q, out_valid_q, out_last_q, done_q;
  logic [31:0]                 lines_q;
  logic                        accept, complete, load_new, load_hold, drain, out_free;

  assign drain    = out_valid_q & wr_ready_i;
  assign out_free = ~out_valid_q | wr_ready_i;

  // Completed line: earlier slots from assembly, current word, pad above it.
  always_comb begin
    line_cmp = asm_q;
    for (int k = 0; k < N; k++) begin
      if (k == int'(idx_q))
        line_cmp[k*G_RESULT_WIDTH +: G_RESULT_WIDTH] = res_data_i;
      else if (k > int'(idx_q))
        line_cmp[k*G_RESULT_WIDTH +: G_RESULT_WIDTH] = G_PAD_VALUE;
    end
  end

  always_comb begin
    state_d     = state_q;
    res_ready_o = 1'b0;
    accept      = 1'b0;
    complete    = 1'b0;
    load_new    = 1'b0;
    load_hold   = 1'b0;
    case (state_q)
      S_FILL: begin
        res_ready_o = 1'b1;
        accept      = res_valid_i;
        complete    = res_valid_i & (res_last_i | (idx_q == LAST_IDX));
        if (complete) begin
          if (out_free) load_new = 1'b1;
          else          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (wr_ready_i) begin
          load_hold = 1'b1;
          state_d   = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FILL;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      hold_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      lines_q     <= '0;
    end else begin
      done_q <= drain & out_last_q;
      if (drain) lines_q <= lines_q + 32'd1;

      if (accept) begin
        if (complete) begin
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
          for (int k = 0; k < N; k++)
            if (k == int'(idx_q)) asm_q[k*G_RESULT_WIDTH +: G_RESULT_WIDTH] <= res_data_i;
        end
      end

      // Output register busy: park the finished line until it drains.
      if (complete && !load_new) begin
        asm_q       <= line_cmp;
        hold_last_q <= res_last_i;
      end

      if (load_new) begin
        out_data_q  <= line_cmp;
        out_last_q  <= res_last_i;
        out_valid_q <= 1'b1;
      end else if (load_hold) begin
        out_data_q  <= asm_q;
        out_last_q  <= hold_last_q;
        out_valid_q <= 1'b1;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign wr_data_o  = out_data_q;
  assign wr_valid_o = out_valid_q;
  assign wr_last_o  = out_last_q;
  assign lines_o    = lines_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: stimulus queues expected lines, a negedge monitor
// pops and compares each output handshake and the done pulse that follows a last line.
module tb_result_packer;
  localparam int W  = 512;
  localparam int RW = 32;
  localparam int N  = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [RW-1:0] res_data_i = '0;
  logic          res_valid_i = 1'b0;
  logic          res_last_i = 1'b0;
  logic          res_ready_o;
  logic [W-1:0]  wr_data_o;
  logic          wr_valid_o;
  logic          wr_last_o;
  logic          wr_ready_i = 1'b1;
  logic [31:0]   lines_o;
  logic          done_o;

  result_packer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .res_data_i(res_data_i), .res_valid_i(res_valid_i), .res_last_i(res_last_i),
    .res_ready_o(res_ready_o),
    .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o), .wr_last_o(wr_last_o),
    .wr_ready_i(wr_ready_i), .lines_o(lines_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           failures = 0;
  int           hs_count = 0;
  logic         exp_done = 1'b0;
  logic [W-1:0] acc = '1;
  int           acc_idx = 0;
  int           last_wait = 0;
  logic         stream_mon = 1'b0;
  int           stall_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected line builder: unwritten slots keep the all-ones pad value.
  task automatic push_word(input logic [RW-1:0] d, input logic l);
    for (int k = 0; k < N; k++)
      if (k == acc_idx) acc[k*RW +: RW] = d;
    acc_idx++;
    if (l || acc_idx == N) begin
      sb_q.push_back('{acc, l});
      acc = '1;
      acc_idx = 0;
    end
  endtask

  task automatic send_word(input logic [RW-1:0] d, input logic l);
    logic rdy;
    int n;
    push_word(d, l);
    res_valid_i = 1'b1;
    res_data_i  = d;
    res_last_i  = l;
    n = 0;
    do begin
      @(negedge clk_i);
      rdy = res_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!rdy && n < 200);
    last_wait = n;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
    res_valid_i = 1'b0;
    res_last_i  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(posedge clk_i);
    #1;
    chk("drain_queue_empty", W'(sb_q.size()), W'(0));
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_i       = 1'b1;
    res_valid_i = 1'b0;
    res_last_i  = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb_q.delete();
    acc     = '1;
    acc_idx = 0;
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_done = 1'b0;
    end else begin
      if (exp_done || done_o) chk("done_o", W'(done_o), W'(exp_done));
      exp_done = 1'b0;
      if (wr_valid_o && wr_ready_i) begin
        exp_t e;
        hs_count++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_line actual=%0h required=none", wr_data_o);
        end else begin
          e = sb_q.pop_front();
          chk("line_data", wr_data_o, e.data);
          chk("line_last", W'(wr_last_o), W'(e.last));
          exp_done = e.last;
        end
      end
      if (stream_mon && !res_ready_o) stall_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_line;
    logic [W-1:0] held;
    int           hs_before;
    int           total;

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_res_ready", W'(res_ready_o), W'(1));
    chk("rst_wr_valid", W'(wr_valid_o), W'(0));
    chk("rst_wr_last", W'(wr_last_o), W'(0));
    chk("rst_lines", W'(lines_o), W'(0));
    chk("rst_done", W'(done_o), W'(0));
    @(posedge clk_i);
    #1;

    // 16 words 0..15, full line, 1-cycle latency
    for (int i = 0; i < 15; i++) send_word(RW'(i), 1'b0);
    chk("t1_valid_before", W'(wr_valid_o), W'(0));
    send_word(RW'(15), 1'b0);
    chk("t1_valid_after", W'(wr_valid_o), W'(1));
    chk("t1_last", W'(wr_last_o), W'(0));
    wait_drain();
    chk("t1_lines", W'(lines_o), W'(1));

    // A,B,C with last on C: padded line
    send_word(32'hA, 1'b0);
    send_word(32'hB, 1'b0);
    send_word(32'hC, 1'b1);
    exp_line = {{13{32'hFFFF_FFFF}}, 32'hC, 32'hB, 32'hA};
    chk("t2_pad_line", wr_data_o, exp_line);
    chk("t2_last", W'(wr_last_o), W'(1));
    wait_drain();
    chk("t2_lines", W'(lines_o), W'(2));

    // Downstream stalled: line 1 in output, line 2 held, input back-pressured
    wr_ready_i = 1'b0;
    for (int i = 0; i < 32; i++) send_word(RW'(32'h100 + i), 1'b0);
    held = wr_data_o;
    res_valid_i = 1'b1;
    res_data_i  = 32'h120;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("t3_hold_ready", W'(res_ready_o), W'(0));
    end
    chk("t3_out_stable", wr_data_o, held);
    chk("t3_out_slot0", W'(wr_data_o[31:0]), W'(32'h100));
    chk("t3_out_valid", W'(wr_valid_o), W'(1));
    @(posedge clk_i);
    #1;
    hs_before  = hs_count;
    wr_ready_i = 1'b1;
    send_word(32'h120, 1'b0);
    chk("t3_drains_before_w33", W'(hs_count - hs_before), W'(2));
    for (int i = 33; i < 48; i++) send_word(RW'(32'h100 + i), 1'b0);
    wait_drain();
    chk("t3_lines", W'(lines_o), W'(5));

    // 1024 words back-to-back, no bubbles
    total = 0;
    stall_cnt = 0;
    stream_mon = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      send_word(RW'(32'h1000 + i), 1'b0);
      total += last_wait;
    end
    stream_mon = 1'b0;
    chk("t4_cycles", W'(total), W'(1024));
    chk("t4_stalls", W'(stall_cnt), W'(0));
    wait_drain();
    chk("t4_lines", W'(lines_o), W'(69));

    // last on slot 15: full line, no padding
    for (int i = 0; i < 15; i++) send_word(RW'(32'h200 + i), 1'b0);
    send_word(32'h20F, 1'b1);
    chk("t6_last", W'(wr_last_o), W'(1));
    chk("t6_slot15", W'(wr_data_o[511:480]), W'(32'h20F));
    chk("t6_slot14", W'(wr_data_o[479:448]), W'(32'h20E));
    wait_drain();
    chk("t6_lines", W'(lines_o), W'(70));

    // Reset mid-line discards the partial line
    for (int i = 0; i < 5; i++) send_word(RW'(32'hDEAD_0000 + i), 1'b0);
    do_reset();
    @(negedge clk_i);
    chk("t5_rst_valid", W'(wr_valid_o), W'(0));
    chk("t5_rst_lines", W'(lines_o), W'(0));
    chk("t5_rst_ready", W'(res_ready_o), W'(1));
    repeat (5) @(posedge clk_i);
    #1;
    chk("t5_no_line", W'(wr_valid_o), W'(0));
    for (int i = 0; i < 16; i++) send_word(RW'(32'h300 + i), 1'b0);
    chk("t5_fresh_slot0", W'(wr_data_o[31:0]), W'(32'h300));
    wait_drain();
    chk("t5_lines", W'(lines_o), W'(1));

    chk("final_queue_empty", W'(sb_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
